// File: rtl/regfile_ctrl_if.sv
// Register-file write controller bus.
// Groups the writeback and debug write requests, the sweep control and the
// register-file write port driven by regfile_ctrl.
//   wb_valid/wb_rd/wb_data, wb_ready    : writeback write request and grant
//   dbg_valid/dbg_rd/dbg_data, dbg_ready : debug write request and grant
//   clr_start, busy                     : zeroing sweep request and status
//   rd, rd_in                           : register-file destination and data
interface regfile_ctrl_if;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_ready;
  logic        dbg_valid;
  logic [4:0]  dbg_rd;
  logic [31:0] dbg_data;
  logic        dbg_ready;
  logic        clr_start;
  logic        busy;
  logic [4:0]  rd;
  logic [31:0] rd_in;

  // Requester side (drives requests, observes grants and the write port).
  modport master (
    output wb_valid, wb_rd, wb_data, dbg_valid, dbg_rd, dbg_data, clr_start,
    input  wb_ready, dbg_ready, busy, rd, rd_in
  );

  // Controller side.
  modport slave (
    input  wb_valid, wb_rd, wb_data, dbg_valid, dbg_rd, dbg_data, clr_start,
    output wb_ready, dbg_ready, busy, rd, rd_in
  );
endinterface

// File: rtl/regfile_ctrl.sv
// Register-file write controller.
// Arbitrates writeback and debug write requests onto a single register-file
// write port, with a bounded-starvation guarantee for debug, and can sweep
// registers 1..31 to zero.
//   clk    : clock, rising edge
//   rs_n_i : asynchronous active-low reset
//   bus    : regfile_ctrl_if.slave (requests, grants, sweep control, write port)
// rd/rd_in are registered: a grant in one cycle appears on the write port
// after the next rising edge. Idle cycles write x0, which is a no-op.
module regfile_ctrl #(
  parameter int unsigned STARVE_MAX = 4
) (
  input logic           clk,
  input logic           rs_n_i,
  regfile_ctrl_if.slave bus
);

  localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e      state_q, state_d;
  logic [4:0]  sweep_q, sweep_d;
  logic [3:0]  starve_q, starve_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] rd_in_q, rd_in_d;

  logic arb_en;
  logic starved;
  logic wb_gnt;
  logic dbg_gnt;

  // Grants are computed from the valids only, never from each other's grant.
  // Gated by reset so both grants drop the moment reset is asserted.
  always_comb begin
    arb_en  = rs_n_i && (state_q == StIdle) && !bus.clr_start;
    starved = (starve_q == StarveMax);
    dbg_gnt = arb_en && bus.dbg_valid && (!bus.wb_valid || starved);
    wb_gnt  = arb_en && bus.wb_valid && !(bus.dbg_valid && starved);
  end

  always_comb begin
    state_d  = state_q;
    sweep_d  = sweep_q;
    starve_d = starve_q;
    rd_d     = '0;
    rd_in_d  = '0;
    case (state_q)
      StIdle: begin
        if (bus.clr_start) begin
          state_d = StClear;
          sweep_d = 5'd1;
        end else if (wb_gnt) begin
          rd_d    = bus.wb_rd;
          rd_in_d = bus.wb_data;
        end else if (dbg_gnt) begin
          rd_d    = bus.dbg_rd;
          rd_in_d = bus.dbg_data;
        end
        // Counts writeback wins while debug is kept waiting.
        if (dbg_gnt || !bus.dbg_valid) begin
          starve_d = '0;
        end else if (wb_gnt && !starved) begin
          starve_d = starve_q + 4'd1;
        end
      end
      StClear: begin
        // clr_start is deliberately ignored here; starvation count holds.
        rd_d = sweep_q;
        if (sweep_q == 5'd31) begin
          state_d = StIdle;
          sweep_d = '0;
        end else begin
          sweep_d = sweep_q + 5'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rs_n_i) begin
    if (!rs_n_i) begin
      state_q  <= StIdle;
      sweep_q  <= '0;
      starve_q <= '0;
      rd_q     <= '0;
      rd_in_q  <= '0;
    end else begin
      state_q  <= state_d;
      sweep_q  <= sweep_d;
      starve_q <= starve_d;
      rd_q     <= rd_d;
      rd_in_q  <= rd_in_d;
    end
  end

  assign bus.wb_ready  = wb_gnt;
  assign bus.dbg_ready = dbg_gnt;
  assign bus.busy      = (state_q == StClear);
  assign bus.rd        = rd_q;
  assign bus.rd_in     = rd_in_q;

endmodule
